dual_issue_queue: RTL and testbench
===================================

DUAL_ISSUE_QUEUE -- requirements
Module: dual_issue_queue

Interface
REQ-001 Parameter: DEPTH, default 8, queue capacity in 32-bit instructions; power of two, minimum 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream fetch presents an instruction pair.
REQ-005 Port: in_instr1  input  32  older instruction of pair, bit 0 MSB.
REQ-006 Port: in_instr2  input  32  younger instruction of pair, bit 0 MSB.
REQ-007 Port: in_ready  output  1  queue can accept a pair this cycle.
REQ-008 Port: stall  input  1  downstream holds issue outputs; no dequeue.
REQ-009 Port: flush  input  1  discard all queued and issued-but-held instructions.
REQ-010 Port: issue_valid1  output  1  slot 1 (older) holds a valid instruction.
REQ-011 Port: issue_instr1  output  32  slot 1 instruction.
REQ-012 Port: issue_valid2  output  1  slot 2 (younger) holds a valid instruction.
REQ-013 Port: issue_instr2  output  32  slot 2 instruction.
REQ-014 Port: count  output  clog2(DEPTH)+1  number of instructions currently in queue, excluding issue registers.

Function
REQ-015 Storage: circular buffer of DEPTH entries; head and tail pointers wrap modulo DEPTH.
REQ-016 in_ready is combinational: 1 when (DEPTH - count) >= 2, evaluated on current count, independent of same-cycle dequeue.
REQ-017 Push: in_valid && in_ready && !flush writes in_instr1 at tail, in_instr2 at tail+1; tail advances by 2.
REQ-018 in_valid while in_ready=0 is ignored; no write, no state change; upstream holds the pair.
REQ-019 Issue registers update on every edge where !stall and !flush; contents come from queue state before that edge's push.
REQ-020 Slot 1 loads entry[head] with issue_valid1=1 when count>=1; otherwise issue_valid1=0, issue_instr1=0.
REQ-021 Slot 2 loads entry[head+1] with issue_valid2=1 only when count>=2 and no hazard; otherwise issue_valid2=0, issue_instr2=0.
REQ-022 Field layout: RT = bits 25:31, RA = bits 18:24, RB = bits 11:17.
REQ-023 Hazard: RT(entry[head]) equals RA or RB of entry[head+1]; on hazard only slot 1 issues and entry[head+1] remains at new head.
REQ-024 Pop count equals number of valid slots loaded (0, 1 or 2); head advances by pop count.
REQ-025 count next = count + 2*push - pop; simultaneous push and pop in one cycle are both honoured.
REQ-026 Latency: a pair pushed at edge N is eligible for issue registers at edge N+1 at the earliest (no bypass from input to outputs).
REQ-027 Ordering: instructions issue strictly in push order; slot 2 never holds an instruction older than slot 1.
REQ-028 stall=1: issue registers, head and issue_valid* hold; push still permitted if in_ready.
REQ-029 flush=1: head=tail=0, count=0, issue_valid1/2=0, issue_instr1/2=0 next edge; flush overrides push, pop and stall.
REQ-030 Full queue (count=DEPTH) or count=DEPTH-1: in_ready=0; no overwrite of unissued entries under any input.
REQ-031 Empty queue: issue_valid1=issue_valid2=0 after next unstalled edge.

Reset
REQ-032 rst=1 at rising edge: head=0, tail=0, count=0, issue_valid1=0, issue_valid2=0, issue_instr1=0, issue_instr2=0; rst overrides flush, push and stall.
REQ-033 Buffer contents need not be cleared on reset; they are unobservable until rewritten.
REQ-034 Reset mid-operation discards all queued instructions; first post-reset push behaves as into empty queue.

Verification
REQ-035 Reset, push pair (0x00000081, 0x00000102; no hazard), stall=0 -> next edge issue_valid1=1 instr1=0x00000081, issue_valid2=1 instr2=0x00000102, count=0.
REQ-036 Push pair with RT(instr1)=5 and RA(instr2)=5 -> first edge issues slot 1 only, issue_valid2=0; following edge issues instr2 in slot 1.
REQ-037 stall=1, push 4 pairs with DEPTH=8 -> count=8, in_ready=0; fifth pair ignored; release stall -> 8 instructions issue in order, two per cycle.
REQ-038 Push every cycle with stall toggling, across tail wrap -> issued sequence equals pushed sequence, no loss or duplication.
REQ-039 count=6, assert flush with in_valid=1 -> next edge count=0, issue_valid1/2=0, pushed pair dropped, in_ready=1.
REQ-040 rst asserted with count=4 and stall=1 -> next edge all outputs zero, count=0, in_ready=1.

Source files
------------

// File: rtl/dual_issue_queue.sv
// Dual-issue instruction queue: a circular buffer that accepts instruction pairs
// and issues up to two per cycle in order, holding back the younger one on a register hazard.
module dual_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [31:0]            in_instr1,
    input  logic [31:0]            in_instr2,
    output logic                   in_ready,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   issue_valid1,
    output logic [31:0]            issue_instr1,
    output logic                   issue_valid2,
    output logic [31:0]            issue_instr2,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Instruction fields use MSB-0 numbering, so RT = bits 25:31 is the low 7 bits.
    function automatic logic [6:0] rt_of(input logic [31:0] instr);
        return instr[6:0];
    endfunction

    function automatic logic [6:0] ra_of(input logic [31:0] instr);
        return instr[13:7];
    endfunction

    function automatic logic [6:0] rb_of(input logic [31:0] instr);
        return instr[20:14];
    endfunction

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid1_q, valid1_d, valid2_q, valid2_d;
    logic [31:0]   instr1_q, instr1_d, instr2_q, instr2_d;

    logic [AW-1:0] head_nxt, tail_nxt;
    logic [31:0]   entry0, entry1;
    logic          hazard, push, can1, can2;
    logic [1:0]    pop;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        head_nxt = head_q + AW'(1);
        tail_nxt = tail_q + AW'(1);
        entry0   = mem_q[head_q];
        entry1   = mem_q[head_nxt];
        hazard   = (rt_of(entry0) == ra_of(entry1)) || (rt_of(entry0) == rb_of(entry1));
        in_ready = (count_q <= CW'(DEPTH - 2));
        push     = in_valid && in_ready && !flush;
        can1     = (count_q >= CW'(1));
        can2     = (count_q >= CW'(2)) && !hazard;
        pop      = 2'd0;

        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        instr1_d = instr1_q;
        instr2_d = instr2_q;

        if (flush) begin
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            instr1_d = '0;
            instr2_d = '0;
        end else begin
            // Issue slots load from pre-push state, so a pair never bypasses the buffer.
            if (!stall) begin
                valid1_d = can1;
                instr1_d = can1 ? entry0 : 32'd0;
                valid2_d = can2;
                instr2_d = can2 ? entry1 : 32'd0;
                pop      = {1'b0, can1} + {1'b0, can2};
            end
            if (push) begin
                tail_d = tail_q + AW'(2);
            end
            head_d  = head_q + AW'(pop);
            count_d = count_q + (push ? CW'(2) : CW'(0)) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            instr1_q <= '0;
            instr2_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            instr1_q <= instr1_d;
            instr2_q <= instr2_d;
        end
    end

    // NOTE: the buffer is left unreset; entries are unobservable until rewritten by a push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[tail_q]   <= in_instr1;
            mem_q[tail_nxt] <= in_instr2;
        end
    end

    assign issue_valid1 = valid1_q;
    assign issue_instr1 = instr1_q;
    assign issue_valid2 = valid2_q;
    assign issue_instr2 = instr2_q;
    assign count        = count_q;

endmodule

// File: tb/tb_dual_issue_queue.sv
// Self-checking bench for dual_issue_queue: directed stimulus feeds a scoreboard of
// expected issue order; a negedge monitor pops and compares every newly loaded slot.
module tb_dual_issue_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr1;
    logic [31:0] in_instr2;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        issue_valid1;
    logic [31:0] issue_instr1;
    logic        issue_valid2;
    logic [31:0] issue_instr2;
    logic [3:0]  count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    logic        load_evt = 1'b0;

    dual_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr1    (in_instr1),
        .in_instr2    (in_instr2),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .issue_valid1 (issue_valid1),
        .issue_instr1 (issue_instr1),
        .issue_valid2 (issue_valid2),
        .issue_instr2 (issue_instr2),
        .count        (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one pair for a single edge; the expected issue order is queued only if acceptance is expected.
    task automatic push_pair(input logic [31:0] a, input logic [31:0] b, input bit expect_accept);
        in_valid  = 1'b1;
        in_instr1 = a;
        in_instr2 = b;
        if (expect_accept) begin
            sb.push_back(a);
            sb.push_back(b);
        end
        tick();
        in_valid  = 1'b0;
        in_instr1 = '0;
        in_instr2 = '0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_count"},  32'(count), 32'd0);
        check({tag, "_ready"},  32'(in_ready), 32'd1);
        check({tag, "_v1"},     32'(issue_valid1), 32'd0);
        check({tag, "_v2"},     32'(issue_valid2), 32'd0);
        check({tag, "_i1"},     issue_instr1, 32'd0);
        check({tag, "_i2"},     issue_instr2, 32'd0);
    endtask

    // Issue registers only reload on an edge without rst, flush or stall.
    always @(posedge clk) load_evt <= !rst && !flush && !stall;

    always @(negedge clk) begin
        if (load_evt) begin
            if (issue_valid2) check("slot2_needs_slot1", 32'(issue_valid1), 32'd1);
            if (issue_valid1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue1: got %h expected nothing", issue_instr1);
                end else begin
                    check("issue1_order", issue_instr1, sb.pop_front());
                end
            end
            if (issue_valid2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue2: got %h expected nothing", issue_instr2);
                end else begin
                    check("issue2_order", issue_instr2, sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sent;
        int cyc;
        bit acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_instr1 = '0;
        in_instr2 = '0;
        stall     = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_idle("reset");

        // Basic pair, no hazard: both issue one edge after the push.
        push_pair(32'h0000_0081, 32'h0000_0102, 1'b1);
        check("basic_count_after_push", 32'(count), 32'd2);
        check("basic_no_bypass", 32'(issue_valid1), 32'd0);
        tick();
        check("basic_v1", 32'(issue_valid1), 32'd1);
        check("basic_i1", issue_instr1, 32'h0000_0081);
        check("basic_v2", 32'(issue_valid2), 32'd1);
        check("basic_i2", issue_instr2, 32'h0000_0102);
        check("basic_count", 32'(count), 32'd0);
        tick();
        check("empty_v1", 32'(issue_valid1), 32'd0);
        check("empty_v2", 32'(issue_valid2), 32'd0);

        // RA hazard: RT(older)=5, RA(younger)=5.
        push_pair(32'h0000_0005, 32'h0000_0283, 1'b1);
        tick();
        check("hazra_v1", 32'(issue_valid1), 32'd1);
        check("hazra_i1", issue_instr1, 32'h0000_0005);
        check("hazra_v2", 32'(issue_valid2), 32'd0);
        check("hazra_i2", issue_instr2, 32'd0);
        check("hazra_count", 32'(count), 32'd1);
        tick();
        check("hazra_next_i1", issue_instr1, 32'h0000_0283);
        check("hazra_next_v2", 32'(issue_valid2), 32'd0);
        check("hazra_next_count", 32'(count), 32'd0);
        tick();

        // RB hazard: RT(older)=10, RB(younger)=10.
        push_pair(32'h0000_000A, 32'h0002_8001, 1'b1);
        tick();
        check("hazrb_v2", 32'(issue_valid2), 32'd0);
        check("hazrb_count", 32'(count), 32'd1);
        tick();
        tick();

        // Fill to DEPTH under stall, fifth pair rejected, then drain two per cycle.
        stall = 1'b1;
        for (int k = 0; k < 4; k++)
            push_pair(32'h1000_0001 + 32'(2 * k), 32'h1000_0002 + 32'(2 * k), 1'b1);
        check("full_count", 32'(count), 32'd8);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_held_v1", 32'(issue_valid1), 32'd0);
        push_pair(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0);
        check("full_reject_count", 32'(count), 32'd8);
        stall = 1'b0;
        tick();
        check("drain_i1", issue_instr1, 32'h1000_0001);
        check("drain_i2", issue_instr2, 32'h1000_0002);
        check("drain_count", 32'(count), 32'd6);
        check("drain_ready", 32'(in_ready), 32'd1);
        tick();
        tick();
        tick();
        check("drain_last_i2", issue_instr2, 32'h1000_0008);
        check("drain_done_count", 32'(count), 32'd0);
        tick();

        // Continuous pushes with stall toggling, wrapping the pointers several times.
        sent = 0;
        cyc  = 0;
        while (sent < 12 && cyc < 200) begin
            in_valid  = 1'b1;
            in_instr1 = 32'h2000_0001 + 32'(2 * sent);
            in_instr2 = 32'h2000_0002 + 32'(2 * sent);
            stall     = (cyc % 3 == 1);
            acc       = in_ready;
            if (acc) begin
                sb.push_back(in_instr1);
                sb.push_back(in_instr2);
            end
            tick();
            if (acc) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        stall    = 1'b0;
        check("stream_all_sent", 32'(sent), 32'd12);
        repeat (8) tick();
        check("stream_sb_empty", 32'(sb.size()), 32'd0);
        check("stream_count", 32'(count), 32'd0);

        // Flush at count=6 with a pair offered: everything dropped.
        stall = 1'b1;
        for (int k = 0; k < 3; k++)
            push_pair(32'h3000_0001 + 32'(2 * k), 32'h3000_0002 + 32'(2 * k), 1'b1);
        check("preflush_count", 32'(count), 32'd6);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr1 = 32'h3333_0001;
        in_instr2 = 32'h3333_0002;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        sb.delete();
        check_idle("flush");
        tick();
        tick();
        check("postflush_count", 32'(count), 32'd0);
        check("postflush_v1", 32'(issue_valid1), 32'd0);
        push_pair(32'h4000_0001, 32'h4000_0002, 1'b1);
        tick();
        check("postflush_i1", issue_instr1, 32'h4000_0001);
        check("postflush_i2", issue_instr2, 32'h4000_0002);

        // Reset with count=4, stall and flush asserted and valid issue slots.
        push_pair(32'h5000_0001, 32'h5000_0002, 1'b1);
        tick();
        stall = 1'b1;
        push_pair(32'h5000_0003, 32'h5000_0004, 1'b1);
        push_pair(32'h5000_0005, 32'h5000_0006, 1'b1);
        check("prerst_count", 32'(count), 32'd4);
        check("prerst_v1", 32'(issue_valid1), 32'd1);
        rst       = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr1 = 32'h6666_0001;
        in_instr2 = 32'h6666_0002;
        tick();
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        sb.delete();
        check_idle("midrst");
        push_pair(32'h7000_0001, 32'h7000_0002, 1'b1);
        check("postrst_count", 32'(count), 32'd2);
        tick();
        check("postrst_i1", issue_instr1, 32'h7000_0001);
        check("postrst_i2", issue_instr2, 32'h7000_0002);
        tick();
        tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
